// File: rtl/vga_scan_ctrl.sv
// VGA raster scan controller: h/v timing, sync generation and pixel FIFO
// draining, with blank-and-resync recovery on FIFO underflow.
module vga_scan_ctrl #(
    parameter int   COLOR_DEPTH = 4,
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_POL    = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     fifo_empty,
    input  logic [3*COLOR_DEPTH-1:0] fifo_rdata,
    output logic                     fifo_rd,
    output logic                     fifo_flush,
    output logic                     frame_req,
    output logic [COLOR_DEPTH-1:0]   r,
    output logic [COLOR_DEPTH-1:0]   g,
    output logic [COLOR_DEPTH-1:0]   b,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     underflow,
    input  logic                     underflow_clr
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CD      = COLOR_DEPTH;

    localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] H_END = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] V_END = VW'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        RESYNC,
        RUN
    } state_t;

    state_t        state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic scan;
    logic active;
    logic hs_on;
    logic vs_on;
    logic vblank_start;
    logic frame_end;
    logic uf_evt;

    assign scan         = en && (state != IDLE);
    assign active       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_on        = (h_cnt >= H_SS) && (h_cnt <= H_SE);
    assign vs_on        = (v_cnt >= V_SS) && (v_cnt <= V_SE);
    assign vblank_start = (h_cnt == '0) && (v_cnt == V_ACT);
    assign frame_end    = (h_cnt == H_END) && (v_cnt == V_END);

    // A read or an underflow only ever happens while displaying.
    assign fifo_rd = en && (state == RUN) && active && !fifo_empty;
    assign uf_evt  = en && (state == RUN) && active && fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            h_cnt      <= '0;
            v_cnt      <= '0;
            r          <= '0;
            g          <= '0;
            b          <= '0;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            frame_req  <= 1'b0;
            fifo_flush <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (!scan) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (h_cnt == H_END) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_END) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end

            if (!en) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE:    state <= RESYNC;
                    RESYNC:  if (frame_end) state <= RUN;
                    RUN:     if (uf_evt) state <= RESYNC;
                    default: state <= IDLE;
                endcase
            end

            r <= fifo_rd ? fifo_rdata[CD-1:0]      : '0;
            g <= fifo_rd ? fifo_rdata[2*CD-1:CD]   : '0;
            b <= fifo_rd ? fifo_rdata[3*CD-1:2*CD] : '0;

            hsync <= (scan && hs_on) ? SYNC_POL : ~SYNC_POL;
            vsync <= (scan && vs_on) ? SYNC_POL : ~SYNC_POL;

            // Flush only while resyncing so a running frame is never cut.
            frame_req  <= scan && vblank_start;
            fifo_flush <= scan && (state == RESYNC) && vblank_start;

            if (uf_evt)
                underflow <= 1'b1;
            else if (underflow_clr)
                underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl with a 14x7 raster; every output is
// recorded per cycle and checked against hand-derived cycle numbers.
module tb_vga_scan_ctrl;

    localparam int N = 640;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic        fifo_empty;
    logic [11:0] fifo_rdata;
    logic        fifo_rd;
    logic        fifo_flush;
    logic        frame_req;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        hsync;
    logic        vsync;
    logic        underflow;
    logic        underflow_clr;

    int errs;
    int checks;

    logic [N-1:0] rd_v;
    logic [N-1:0] hl_v;
    logic [N-1:0] vl_v;
    logic [N-1:0] fr_v;
    logic [N-1:0] fl_v;
    logic [N-1:0] uf_v;
    logic [11:0]  pix_a [0:N-1];

    vga_scan_ctrl #(
        .COLOR_DEPTH (4),
        .H_ACTIVE    (8),
        .H_FP        (2),
        .H_SYNC      (2),
        .H_BP        (2),
        .V_ACTIVE    (4),
        .V_FP        (1),
        .V_SYNC      (1),
        .V_BP        (1),
        .SYNC_POL    (1'b0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .fifo_empty    (fifo_empty),
        .fifo_rdata    (fifo_rdata),
        .fifo_rd       (fifo_rd),
        .fifo_flush    (fifo_flush),
        .frame_req     (frame_req),
        .r             (r),
        .g             (g),
        .b             (b),
        .hsync         (hsync),
        .vsync         (vsync),
        .underflow     (underflow),
        .underflow_clr (underflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: head word steps by 0x333 on every pop.
    always @(posedge clk)
        if (fifo_rd) fifo_rdata <= fifo_rdata + 12'h333;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ones(input logic [N-1:0] v, input int a,
                                input int e);
        int n;
        n = 0;
        for (int i = a; i < e; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int first(input logic [N-1:0] v, input int a,
                                 input int e);
        for (int i = a; i < e; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic stim(input int k);
        case (k)
            311: fifo_empty = 1'b1;
            312: fifo_empty = 1'b0;
            400: underflow_clr = 1'b1;
            401: underflow_clr = 1'b0;
            409: begin fifo_empty = 1'b1; underflow_clr = 1'b1; end
            410: begin fifo_empty = 1'b0; underflow_clr = 1'b0; end
            495: en = 1'b0;
            515: en = 1'b1;
            default: ;
        endcase
    endtask

    int bad;
    int fr_exp [6] = '{57, 155, 253, 351, 449, 573};
    int fl_exp [4] = '{57, 351, 449, 573};
    int nz;

    initial begin
        errs          = 0;
        checks        = 0;
        reset_n       = 1'b0;
        en            = 1'b0;
        fifo_empty    = 1'b1;
        underflow_clr = 1'b0;
        fifo_rdata    = 12'h123;

        repeat (3) @(posedge clk);
        #1;
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_rgb", {b, g, r}, 0);
        check("rst_freq", frame_req, 0);
        check("rst_flush", fifo_flush, 0);
        check("rst_uf", underflow, 0);
        check("rst_rd", fifo_rd, 0);

        reset_n    = 1'b1;
        fifo_empty = 1'b0;
        bad        = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (fifo_rd || frame_req || fifo_flush || !hsync || !vsync ||
                {b, g, r} != 0)
                bad++;
        end
        check("idle_quiet", bad, 0);

        en = 1'b1;
        for (int k = 0; k < N; k++) begin
            @(posedge clk);
            #1;
            stim(k);
            #1;
            rd_v[k]  = fifo_rd;
            hl_v[k]  = !hsync;
            vl_v[k]  = !vsync;
            fr_v[k]  = frame_req;
            fl_v[k]  = fifo_flush;
            uf_v[k]  = underflow;
            pix_a[k] = {b, g, r};
        end

        // startup and read pattern
        check("f0_reads", ones(rd_v, 0, 98), 0);
        check("f1_reads", ones(rd_v, 98, 196), 32);
        check("f2_reads", ones(rd_v, 196, 294), 32);
        check("line_run", ones(rd_v, 98, 106), 8);
        check("line_gap", rd_v[106], 0);
        check("freq_cnt", ones(fr_v, 0, N), 6);
        foreach (fr_exp[i]) check("freq_at", fr_v[fr_exp[i]], 1);
        check("flush_cnt", ones(fl_v, 0, N), 4);
        foreach (fl_exp[i]) check("flush_at", fl_v[fl_exp[i]], 1);

        // sync geometry
        check("hs_first", first(hl_v, 0, 14), 11);
        check("hs_width", ones(hl_v, 0, 14), 2);
        check("vs_first", first(vl_v, 0, 98), 71);
        check("vs_width", ones(vl_v, 0, 98), 14);
        check("vs_period", first(vl_v, 98, 196), 169);

        // data path
        nz = 0;
        for (int i = 0; i < 99; i++) if (pix_a[i] != 0) nz++;
        check("f0_blank", nz, 0);
        check("pix0", pix_a[99], 12'h123);
        check("pix1", pix_a[100], 12'h456);
        check("pix2", pix_a[101], 12'h789);
        check("pix_hblank", pix_a[107], 0);

        // underflow and recovery
        check("uf_rd", rd_v[311], 0);
        check("uf_rgb", pix_a[312], 0);
        check("uf_pre", uf_v[311], 0);
        check("uf_set", uf_v[312], 1);
        check("f3_reads", ones(rd_v, 294, 392), 11);
        check("run_again", rd_v[392], 1);
        check("uf_sticky", uf_v[392], 1);
        check("uf_clr", uf_v[401], 0);
        check("uf_set_win", uf_v[410], 1);
        check("f4_reads", ones(rd_v, 392, 490), 11);

        // disable mid-line and restart
        check("f5_reads", ones(rd_v, 490, 495), 5);
        check("dis_rd", rd_v[495], 0);
        check("dis_hs", hl_v[496], 0);
        check("dis_vs", vl_v[496], 0);
        check("dis_hs_idle", ones(hl_v, 496, 517), 0);
        check("re_reads", ones(rd_v, 495, 614), 0);
        check("re_first", rd_v[614], 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Scan controller for the VGA Avalon slave. It generates the raster timing (h/v counters and sync pulses) and pops pixels from the show-ahead pixel FIFO during active video. It asks the frame-buffer DMA for a new frame once per vertical blank. On FIFO underflow it blanks the screen and resynchronises at the next frame boundary, so tearing cannot persist.

## Interface
Parameters:
- COLOR_DEPTH, 4, bits per colour channel
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports (clk / reset_n: one clock; reset is synchronous and active-low):
- clk  in  1  pixel clock (25 MHz for defaults)
- reset_n  in  1  synchronous active-low reset
- en  in  1  scan enable
- fifo_empty  in  1  pixel FIFO empty
- fifo_rdata  in  3*COLOR_DEPTH  FIFO head word, packed {b,g,r}, valid when !fifo_empty
- fifo_rd  out  1  pop FIFO head (combinational)
- fifo_flush  out  1  one-cycle FIFO flush request
- frame_req  out  1  one-cycle request to DMA to start fetching the next frame
- r, g, b  out  COLOR_DEPTH each  registered colour outputs
- hsync, vsync  out  1  registered sync outputs
- underflow  out  1  sticky underflow flag
- underflow_clr  in  1  clears underflow

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise.
- h_cnt runs 0..H_TOTAL-1. v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1. Counter widths are $clog2 of the totals.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hsync is asserted while H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on v_cnt with the V parameters. Asserted means level SYNC_POL.
- vblank_start = (h_cnt==0 && v_cnt==V_ACTIVE). frame_end = (h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1).
- FSM states:
  - IDLE: counters held at 0; fifo_rd=0; outputs at inactive values. Goes to RESYNC when en=1.
  - RESYNC: counters run; no FIFO reads; rgb=0. fifo_flush and frame_req pulse together on vblank_start. Goes to RUN on frame_end.
  - RUN:
    - fifo_rd = active && !fifo_empty.
    - frame_req pulses on each vblank_start; fifo_flush stays 0.
    - active && fifo_empty is an underflow: rgb=0 that cycle, underflow set, next state RESYNC.
- Entry from IDLE lands at h=v=0 inside active video. RESYNC therefore always blanks the first partial frame and flushes before display begins.
- en=0 in any state: next state IDLE, counters cleared the following cycle, no further fifo_rd/frame_req/fifo_flush.
- underflow: set on an underflow event, cleared by underflow_clr. When set and clear happen in the same cycle, set wins. underflow is not cleared by en.

## Timing
- Reset values: r=g=b=0, hsync=vsync=~SYNC_POL, fifo_rd=0, fifo_flush=0, frame_req=0, underflow=0, state IDLE, h_cnt=v_cnt=0.
- fifo_rd is combinational from the state, counters and fifo_empty. The FIFO pops on the clk edge where fifo_rd=1.
- Output pipeline is one stage. On cycle t, rgb is captured as fifo_rdata if fifo_rd=1, else 0. hsync/vsync are captured from the counters at t. All of them appear at t+1, aligned with each other.
- frame_req and fifo_flush are registered pulses, high for exactly one cycle, one cycle after the vblank_start counter state.
- The underflow flag rises one cycle after the underflow cycle. The state is RESYNC from the next cycle on. Pixels already registered still drain normally.
- In IDLE, counters do not advance. Raster phase is undefined across en toggles except that it restarts at 0,0.

## Test plan
Small parameters for all tests: H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), SYNC_POL=0, COLOR_DEPTH=4.
- Reset/idle: reset_n=0 for 3 clocks, en=0 → hsync=vsync=1, rgb=0, no pulses, counters frozen for 50 clocks.
- Startup: en=1 with FIFO always full → frame 0 blank with 0 reads. frame_req and fifo_flush pulse once, at cycle 4*14+1 after en. From frame 1, exactly 32 reads per frame, 8 consecutive per line.
- Sync geometry: hsync low for exactly 2 clocks starting 10 clocks after line start (+1 pipeline). vsync low for exactly 14 clocks starting at line 5. Period is 98 clocks.
- Data path: FIFO holds 0x123, 0x456, … → r/g/b equal {b,g,r} slices one cycle after each fifo_rd, and 0 outside active video.
- Underflow: FIFO empties at pixel 3 of line 1 in RUN → rgb=0 at that pixel, underflow=1 next cycle, no reads for the rest of the frame. Flush and frame_req occur at vblank, and RUN resumes at the next frame. underflow_clr and a new underflow in the same cycle → flag stays 1.
- Disable mid-line: en=0 at h_cnt=5 → fifo_rd=0 immediately, syncs inactive and counters 0 next cycle. Re-enable → RESYNC behaviour as in the startup test.
